execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
Execute stage of the 5-stage pipelined core, directly downstream of the decode stage's ID/EX register. It selects forwarded operands, performs the ALU operation, resolves branches (PC redirect to fetch), and registers results into the EX/MEM pipeline register consumed by the memory stage. The register supports stall (hold) and flush (bubble) controls from the hazard unit.

Parameters:
DATA_W, 32, datapath width for operands, PC and results
REG_AW, 5, register-address width (RD_E / RD_M)

Ports:
clk  in  1  clock, all registers on rising edge
rst  in  1  asynchronous, active-low reset
RegWriteE  in  1  register-write enable from ID/EX
ALUSrcE  in  1  0: operand B = forwarded RD2; 1: Imm_Ext_E
MemWriteE  in  1  memory write enable
ResultSrcE  in  1  0: ALU result; 1: memory read data (write-back select)
BranchE  in  1  instruction is conditional branch (taken when Zero)
ALUControlE  in  3  ALU operation
RD1_E  in  DATA_W  register operand A
RD2_E  in  DATA_W  register operand B
Imm_Ext_E  in  DATA_W  sign-extended immediate
RD_E  in  REG_AW  destination register
PCE  in  DATA_W  PC of instruction in EX
PCPlus4E  in  DATA_W  PC+4 of instruction in EX
ForwardAE  in  2  00: RD1_E, 01: ResultW, 10: ALUResultM, 11: RD1_E
ForwardBE  in  2  same encoding for operand B (before ALUSrc mux)
ResultW  in  DATA_W  write-back result
StallE  in  1  hold EX/MEM register contents
FlushE  in  1  load bubble into EX/MEM register
PCSrcE  out  1  branch taken, combinational
PCTargetE  out  DATA_W  PCE + Imm_Ext_E, combinational
RegWriteM  out  1  registered
MemWriteM  out  1  registered
ResultSrcM  out  1  registered
ALUResultM  out  DATA_W  registered ALU result
WriteDataM  out  DATA_W  registered forwarded operand B (pre-ALUSrc mux)
RD_M  out  REG_AW  registered destination
PCPlus4M  out  DATA_W  registered PC+4
FlagsM  out  4  registered {N,Z,C,V}; see Optional Feature

Behaviour:
- SrcA = mux(ForwardAE); forwarded B = mux(ForwardBE); SrcB = ALUSrcE ? Imm_Ext_E : forwarded B. ALUResultM forwarding taps the registered output.
- ALUControlE: 000 add, 001 sub (SrcA-SrcB), 010 and, 011 or, 100 xor, 101 slt (signed, result 1/0), 110 sll, 111 srl (shift amount SrcB[4:0]). Results truncated mod 2^DATA_W.
- Zero = (ALU result == 0). PCSrcE = BranchE & Zero. PCTargetE = PCE + Imm_Ext_E, wrap-around mod 2^DATA_W.
- EX/MEM register latency: 1 cycle. Priority per edge: FlushE > StallE > load.
- FlushE=1: RegWriteM, MemWriteM, ResultSrcM cleared to 0; data fields cleared to 0. FlushE overrides a simultaneous StallE.
- StallE=1 (no flush): all registered outputs hold.
- Reset (rst=0, any time incl. mid-stall): all registered outputs 0 immediately, asynchronously; PCSrcE/PCTargetE remain combinational from inputs.
- ForwardXE=11 treated as 00.
- Carry C = unsigned carry-out for add, NOT borrow for sub, 0 otherwise; V = signed overflow for add/sub, 0 otherwise; N = result MSB.

Optional Feature:
EXEC_FLAGS_EN: defined -> FlagsM is an EX/MEM register field capturing {N,Z,C,V} under the same flush/stall/reset rules (flush clears to 0000). Undefined -> FlagsM tied to 4'b0000, no flag logic or storage synthesized; all other behaviour identical.

Test Plan:
- Reset: rst=0 mid-operation with nonzero register state -> all M outputs 0 immediately; release, ADD RD1=5, Imm=7, ALUSrcE=1 -> next edge ALUResultM=12.
- Forwarding: cycle 1 add 3+4 (ALUResultM=7); cycle 2 ForwardAE=10, RD1_E=0, SrcB=1, sub -> ALUResultM=6; ForwardBE=01, ResultW=9, ALUSrcE=0 -> WriteDataM=9.
- Branch: BranchE=1, sub 10-10, PCE=0x100, Imm=0x20 -> PCSrcE=1, PCTargetE=0x120; RD2=11 -> PCSrcE=0.
- Stall/flush: StallE=1 for 2 cycles -> M outputs hold; FlushE=1 with StallE=1 and RegWriteE=1 -> RegWriteM=0, MemWriteM=0.
- ALU edges: slt -1 vs 1 -> 1; srl 0x80000000 by 31 -> 1; add 0xFFFFFFFF+1 -> 0 (with EXEC_FLAGS_EN: FlagsM=0110).
- Flags overflow (EXEC_FLAGS_EN): add 0x7FFFFFFF+1 -> ALUResultM=0x80000000, FlagsM=1001; without macro FlagsM=0000.

Source files
------------

// File: rtl/execute_cycle_if.sv
// Execute-stage bundle: ID/EX inputs, forwarding/hazard controls, and the
// EX/MEM register outputs plus branch redirect back to fetch.
interface execute_cycle_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              RegWriteE;
  logic              ALUSrcE;
  logic              MemWriteE;
  logic              ResultSrcE;
  logic              BranchE;
  logic [2:0]        ALUControlE;
  logic [DATA_W-1:0] RD1_E;
  logic [DATA_W-1:0] RD2_E;
  logic [DATA_W-1:0] Imm_Ext_E;
  logic [REG_AW-1:0] RD_E;
  logic [DATA_W-1:0] PCE;
  logic [DATA_W-1:0] PCPlus4E;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic [DATA_W-1:0] ResultW;
  logic              StallE;
  logic              FlushE;
  logic              PCSrcE;
  logic [DATA_W-1:0] PCTargetE;
  logic              RegWriteM;
  logic              MemWriteM;
  logic              ResultSrcM;
  logic [DATA_W-1:0] ALUResultM;
  logic [DATA_W-1:0] WriteDataM;
  logic [REG_AW-1:0] RD_M;
  logic [DATA_W-1:0] PCPlus4M;
  logic [3:0]        FlagsM;

  modport master (
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ForwardAE, ForwardBE,
           ResultW, StallE, FlushE,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, ALUResultM,
           WriteDataM, RD_M, PCPlus4M, FlagsM
  );

  modport slave (
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E, ForwardAE, ForwardBE,
           ResultW, StallE, FlushE,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, ALUResultM,
           WriteDataM, RD_M, PCPlus4M, FlagsM
  );
endinterface

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch resolve, EX/MEM register.
// Define EXEC_FLAGS_EN to register {N,Z,C,V} into FlagsM; otherwise FlagsM is 0.
module execute_cycle #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic            clk,
  input  logic            rst,
  execute_cycle_if.slave  bus
);
  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] w_src_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic [DATA_W-1:0] w_src_b;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_zero;

  logic              r_reg_write;
  logic              r_mem_write;
  logic              r_result_src;
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_write_data;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_pc_plus4;

  // Forward select 11 falls back to the register-file operand.
  always_comb begin
    w_src_a = bus.RD1_E;
    case (bus.ForwardAE)
      2'b01:   w_src_a = bus.ResultW;
      2'b10:   w_src_a = r_alu_result;
      default: w_src_a = bus.RD1_E;
    endcase
    w_fwd_b = bus.RD2_E;
    case (bus.ForwardBE)
      2'b01:   w_fwd_b = bus.ResultW;
      2'b10:   w_fwd_b = r_alu_result;
      default: w_fwd_b = bus.RD2_E;
    endcase
    w_src_b = bus.ALUSrcE ? bus.Imm_Ext_E : w_fwd_b;
  end

  always_comb begin
    w_alu_res = '0;
    case (bus.ALUControlE)
      3'b000: w_alu_res = w_src_a + w_src_b;
      3'b001: w_alu_res = w_src_a - w_src_b;
      3'b010: w_alu_res = w_src_a & w_src_b;
      3'b011: w_alu_res = w_src_a | w_src_b;
      3'b100: w_alu_res = w_src_a ^ w_src_b;
      3'b101: w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
      3'b110: w_alu_res = w_src_a << w_src_b[4:0];
      3'b111: w_alu_res = w_src_a >> w_src_b[4:0];
      default: w_alu_res = '0;
    endcase
  end

  assign w_zero        = (w_alu_res == '0);
  assign bus.PCSrcE    = bus.BranchE & w_zero;
  assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

  // Flush beats stall beats load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 1'b0;
      r_alu_result <= '0;
      r_write_data <= '0;
      r_rd         <= '0;
      r_pc_plus4   <= '0;
    end else if (bus.FlushE) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 1'b0;
      r_alu_result <= '0;
      r_write_data <= '0;
      r_rd         <= '0;
      r_pc_plus4   <= '0;
    end else if (!bus.StallE) begin
      r_reg_write  <= bus.RegWriteE;
      r_mem_write  <= bus.MemWriteE;
      r_result_src <= bus.ResultSrcE;
      r_alu_result <= w_alu_res;
      r_write_data <= w_fwd_b;
      r_rd         <= bus.RD_E;
      r_pc_plus4   <= bus.PCPlus4E;
    end
  end

  assign bus.RegWriteM  = r_reg_write;
  assign bus.MemWriteM  = r_mem_write;
  assign bus.ResultSrcM = r_result_src;
  assign bus.ALUResultM = r_alu_result;
  assign bus.WriteDataM = r_write_data;
  assign bus.RD_M       = r_rd;
  assign bus.PCPlus4M   = r_pc_plus4;

`ifdef EXEC_FLAGS_EN
  logic       w_carry;
  logic       w_ovf;
  logic [3:0] r_flags;

  // Carry from MSB bits only; for sub the B operand is inverted, giving NOT borrow.
  always_comb begin
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (bus.ALUControlE)
      3'b000: begin
        w_carry = (w_src_a[MSB] & w_src_b[MSB]) |
                  ((w_src_a[MSB] | w_src_b[MSB]) & ~w_alu_res[MSB]);
        w_ovf   = (w_src_a[MSB] == w_src_b[MSB]) && (w_alu_res[MSB] != w_src_a[MSB]);
      end
      3'b001: begin
        w_carry = (w_src_a[MSB] & ~w_src_b[MSB]) |
                  ((w_src_a[MSB] | ~w_src_b[MSB]) & ~w_alu_res[MSB]);
        w_ovf   = (w_src_a[MSB] != w_src_b[MSB]) && (w_alu_res[MSB] != w_src_a[MSB]);
      end
      default: begin
        w_carry = 1'b0;
        w_ovf   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              r_flags <= 4'b0000;
    else if (bus.FlushE)   r_flags <= 4'b0000;
    else if (!bus.StallE)  r_flags <= {w_alu_res[MSB], w_zero, w_carry, w_ovf};
  end

  assign bus.FlagsM = r_flags;
`else
  assign bus.FlagsM = 4'b0000;
`endif

endmodule

// File: tb/tb_execute_cycle.sv
// Directed self-checking bench for execute_cycle; flag expectations follow
// whether EXEC_FLAGS_EN is defined for the build.
module tb_execute_cycle;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

`ifdef EXEC_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  execute_cycle_if #(.DATA_W(32), .REG_AW(5)) bus ();

  execute_cycle #(.DATA_W(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.RegWriteE   = 1'b0;
    bus.ALUSrcE     = 1'b0;
    bus.MemWriteE   = 1'b0;
    bus.ResultSrcE  = 1'b0;
    bus.BranchE     = 1'b0;
    bus.ALUControlE = 3'b000;
    bus.RD1_E       = '0;
    bus.RD2_E       = '0;
    bus.Imm_Ext_E   = '0;
    bus.RD_E        = '0;
    bus.PCE         = '0;
    bus.PCPlus4E    = '0;
    bus.ForwardAE   = 2'b00;
    bus.ForwardBE   = 2'b00;
    bus.ResultW     = '0;
    bus.StallE      = 1'b0;
    bus.FlushE      = 1'b0;
  endtask

  // Program an ALU op; b is applied through RD2 (ALUSrcE=0) or Imm (ALUSrcE=1).
  task automatic op(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                    input logic use_imm);
    bus.ALUControlE = ctl;
    bus.RD1_E       = a;
    bus.ALUSrcE     = use_imm;
    if (use_imm) bus.Imm_Ext_E = b;
    else         bus.RD2_E     = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle();
    #3;
    check("reset_alu",  bus.ALUResultM, 32'h0);
    check1("reset_rw",  bus.RegWriteM,  1'b0);
    check("reset_flag", 32'(bus.FlagsM), 32'h0);

    rst = 1'b1;
    @(negedge clk);
    op(3'b000, 32'd100, 32'd23, 1'b1);
    bus.RegWriteE = 1'b1; bus.MemWriteE = 1'b1; bus.ResultSrcE = 1'b1;
    bus.RD_E = 5'd17; bus.PCPlus4E = 32'h44; bus.RD2_E = 32'hABCD;
    step();
    check("load_alu",  bus.ALUResultM, 32'd123);
    check1("load_rw",  bus.RegWriteM,  1'b1);
    check1("load_rs",  bus.ResultSrcM, 1'b1);
    check("load_rd",   32'(bus.RD_M),  32'd17);
    check("load_pc4",  bus.PCPlus4M,   32'h44);
    check("load_wd",   bus.WriteDataM, 32'hABCD);

    // Asynchronous reset mid-cycle, with a stall requested as well.
    bus.StallE = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("async_alu", bus.ALUResultM, 32'h0);
    check1("async_mw", bus.MemWriteM,  1'b0);
    check("async_pc4", bus.PCPlus4M,   32'h0);
    check("async_wd",  bus.WriteDataM, 32'h0);
    #1 rst = 1'b1;
    @(negedge clk);
    idle();
    op(3'b000, 32'd5, 32'd7, 1'b1);
    step();
    check("post_rst_add", bus.ALUResultM, 32'd12);

    // Forwarding from the EX/MEM result and from write-back.
    @(negedge clk);
    op(3'b000, 32'd3, 32'd4, 1'b1);
    step();
    check("fwd_base", bus.ALUResultM, 32'd7);
    @(negedge clk);
    op(3'b001, 32'd0, 32'd1, 1'b1);
    bus.ForwardAE = 2'b10;
    step();
    check("fwd_a_mem", bus.ALUResultM, 32'd6);
    @(negedge clk);
    op(3'b000, 32'd1, 32'd2, 1'b0);
    bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b01; bus.ResultW = 32'd9;
    step();
    check("fwd_b_wb_wd",  bus.WriteDataM, 32'd9);
    check("fwd_b_wb_alu", bus.ALUResultM, 32'd10);
    @(negedge clk);
    op(3'b000, 32'd20, 32'd0, 1'b1);
    bus.ForwardBE = 2'b00; bus.ForwardAE = 2'b11; bus.ResultW = 32'd99;
    step();
    check("fwd_11_is_00", bus.ALUResultM, 32'd20);

    // Branch resolution, combinational.
    @(negedge clk);
    idle();
    op(3'b001, 32'd10, 32'd10, 1'b0);
    bus.BranchE = 1'b1; bus.PCE = 32'h100; bus.Imm_Ext_E = 32'h20;
    #1;
    check1("br_taken",  bus.PCSrcE,    1'b1);
    check("br_target",  bus.PCTargetE, 32'h120);
    bus.RD2_E = 32'd11;
    #1;
    check1("br_not_taken", bus.PCSrcE, 1'b0);
    bus.PCE = 32'hFFFF_FFF0; bus.Imm_Ext_E = 32'h20;
    #1;
    check("br_target_wrap", bus.PCTargetE, 32'h10);
    bus.BranchE = 1'b0; bus.RD2_E = 32'd10;
    #1;
    check1("br_no_branch", bus.PCSrcE, 1'b0);
    step();
    check("sub_eq_flags", 32'(bus.FlagsM), FLAGS_ON ? 32'h6 : 32'h0);

    // Stall holds, flush overrides stall.
    @(negedge clk);
    idle();
    op(3'b000, 32'd1, 32'd2, 1'b1);
    bus.RegWriteE = 1'b1; bus.MemWriteE = 1'b1;
    step();
    check("stall_pre", bus.ALUResultM, 32'd3);
    @(negedge clk);
    op(3'b000, 32'd50, 32'd50, 1'b1);
    bus.StallE = 1'b1; bus.MemWriteE = 1'b0;
    step();
    check("stall_hold1", bus.ALUResultM, 32'd3);
    check1("stall_mw1",  bus.MemWriteM,  1'b1);
    step();
    check("stall_hold2", bus.ALUResultM, 32'd3);
    check1("stall_rw2",  bus.RegWriteM,  1'b1);
    @(negedge clk);
    bus.FlushE = 1'b1; bus.RegWriteE = 1'b1; bus.MemWriteE = 1'b1;
    step();
    check1("flush_rw",  bus.RegWriteM,  1'b0);
    check1("flush_mw",  bus.MemWriteM,  1'b0);
    check("flush_alu",  bus.ALUResultM, 32'h0);

    // Logic ops and ALU edge cases.
    @(negedge clk);
    idle();
    op(3'b010, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
    step(); check("and", bus.ALUResultM, 32'h0000_F000);
    @(negedge clk); op(3'b011, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
    step(); check("or",  bus.ALUResultM, 32'h0000_FFF0);
    @(negedge clk); op(3'b100, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
    step(); check("xor", bus.ALUResultM, 32'h0000_0FF0);
    @(negedge clk); op(3'b110, 32'h1, 32'h24, 1'b1);
    step(); check("sll_amt_lo5", bus.ALUResultM, 32'h10);
    @(negedge clk); op(3'b101, 32'hFFFF_FFFF, 32'h1, 1'b0);
    step(); check("slt_neg", bus.ALUResultM, 32'h1);
    @(negedge clk); op(3'b101, 32'h1, 32'hFFFF_FFFF, 1'b0);
    step(); check("slt_pos", bus.ALUResultM, 32'h0);
    @(negedge clk); op(3'b111, 32'h8000_0000, 32'd31, 1'b1);
    step(); check("srl_31", bus.ALUResultM, 32'h1);
    @(negedge clk); op(3'b000, 32'hFFFF_FFFF, 32'h1, 1'b1);
    step();
    check("add_wrap", bus.ALUResultM, 32'h0);
    check("add_wrap_flags", 32'(bus.FlagsM), FLAGS_ON ? 32'h6 : 32'h0);
    @(negedge clk); op(3'b000, 32'h7FFF_FFFF, 32'h1, 1'b1);
    step();
    check("add_ovf", bus.ALUResultM, 32'h8000_0000);
    check("add_ovf_flags", 32'(bus.FlagsM), FLAGS_ON ? 32'h9 : 32'h0);
    @(negedge clk); op(3'b001, 32'h0, 32'h1, 1'b1);
    step();
    check("sub_borrow", bus.ALUResultM, 32'hFFFF_FFFF);
    check("sub_borrow_flags", 32'(bus.FlagsM), FLAGS_ON ? 32'h8 : 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
